vm_inv_arbiter: RTL

//  Owns the item inventory/price table of the vending machine and shares it between two requesters.
//  - Vend path: the purchase FSM queries or dispenses one item.
//  - Supplier path: restocks an item and/or reprices it.

---
 rtl/vm_inv_arbiter_pkg.sv | 16 +
 rtl/vm_inv_table.sv | 68 ++++++
 rtl/vm_inv_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vm_inv_arbiter_pkg.sv
// Shared types and constants for the vending-machine inventory arbiter.
package vm_inv_arbiter_pkg;

  localparam int unsigned ITEM_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    V_RD,
    V_WR,
    S_WR
  } inv_state_t;

  localparam logic VEND_QUERY    = 1'b0;
  localparam logic VEND_DISPENSE = 1'b1;

endpackage

// File: rtl/vm_inv_table.sv
// Inventory table: per-item stock/price registers, one async read port, one write port.
module vm_inv_table
  import vm_inv_arbiter_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned COST_W    = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [ITEM_W-1:0]    rd_item,
  output logic [CNT_W-1:0]     rd_stock,
  output logic [COST_W-1:0]    rd_cost,
  input  logic                 we,
  input  logic [ITEM_W-1:0]    wr_item,
  input  logic [CNT_W-1:0]     wr_stock,
  input  logic [COST_W-1:0]    wr_cost,
  output logic [NUM_ITEMS-1:0] sold_out
);

  typedef struct packed {
    logic [CNT_W-1:0]  stock;
    logic [COST_W-1:0] cost;
  } entry_t;

  entry_t               mem_q [NUM_ITEMS];
  entry_t               mem_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_out_q;

  // Out-of-range indices match no entry: reads return zero, writes are dropped.
  always_comb begin
    rd_stock = '0;
    rd_cost  = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (rd_item == ITEM_W'(i)) begin
        rd_stock = mem_q[i].stock;
        rd_cost  = mem_q[i].cost;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (wr_item == ITEM_W'(i))) begin
        mem_d[i].stock = wr_stock;
        mem_d[i].cost  = wr_cost;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        mem_q[i] <= '0;
      end
      sold_out_q <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        mem_q[i]      <= mem_d[i];
        sold_out_q[i] <= (mem_d[i].stock == '0);
      end
    end
  end

  assign sold_out = sold_out_q;

endmodule

// File: rtl/vm_inv_arbiter.sv
// Arbitrates vend and supplier access to the inventory table, one transaction at a time,
// with supplier priority bounded by a starvation counter.
module vm_inv_arbiter
  import vm_inv_arbiter_pkg::*;
#(
  parameter int unsigned NUM_ITEMS    = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned COST_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 vend_req,
  input  logic                 vend_op,
  input  logic [ITEM_W-1:0]    vend_item,
  output logic                 vend_gnt,
  output logic                 vend_ok,
  output logic [COST_W-1:0]    vend_cost,
  output logic [CNT_W-1:0]     vend_stock,
  input  logic                 sup_req,
  input  logic [ITEM_W-1:0]    sup_item,
  input  logic [CNT_W-1:0]     sup_count,
  input  logic [COST_W-1:0]    sup_cost,
  output logic                 sup_gnt,
  output logic                 sup_sat,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int unsigned      SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  inv_state_t          state_q, state_d;
  logic                op_q;
  logic [ITEM_W-1:0]   item_q;
  logic [CNT_W-1:0]    count_q;
  logic [COST_W-1:0]   pcost_q;
  logic [CNT_W-1:0]    stock_q;
  logic [COST_W-1:0]   cost_q;
  logic                sat_q;
  logic [SC_W-1:0]     starve_q, starve_d;

  logic                sup_win, vend_win, item_ok, sum_over, sat_now;
  logic [CNT_W:0]      sum;
  logic [CNT_W-1:0]    rd_stock, wr_stock;
  logic [COST_W-1:0]   rd_cost, wr_cost;
  logic                we;

  vm_inv_table #(
    .NUM_ITEMS (NUM_ITEMS),
    .CNT_W     (CNT_W),
    .COST_W    (COST_W)
  ) u_table (
    .clk      (clk),
    .srst     (srst),
    .rd_item  (item_q),
    .rd_stock (rd_stock),
    .rd_cost  (rd_cost),
    .we       (we),
    .wr_item  (item_q),
    .wr_stock (wr_stock),
    .wr_cost  (wr_cost),
    .sold_out (sold_out)
  );

  always_comb begin
    sup_win  = (state_q == IDLE) && sup_req &&
               (!vend_req || (starve_q != SC_W'(STARVE_LIMIT)));
    vend_win = (state_q == IDLE) && vend_req && !sup_win;
    item_ok  = 32'(item_q) < NUM_ITEMS;
    sum      = {1'b0, rd_stock} + {1'b0, count_q};
    sum_over = sum > {1'b0, MAX_CNT};
    sat_now  = !item_ok || sum_over;
  end

  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (sup_win) begin
          state_d = S_WR;
          if (vend_req && (starve_q != SC_W'(STARVE_LIMIT))) starve_d = starve_q + SC_W'(1);
        end else if (vend_win) begin
          state_d  = V_RD;
          starve_d = '0;
        end
      end
      V_RD:    state_d = V_WR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vend_gnt = (state_q == V_WR);
    sup_gnt  = (state_q == S_WR);
    busy     = (state_q != IDLE);
    vend_ok  = vend_gnt && item_ok && (stock_q != '0);
    sup_sat  = sup_gnt ? sat_now : sat_q;
    we       = 1'b0;
    wr_stock = rd_stock;
    wr_cost  = rd_cost;
    if (vend_ok && (op_q == VEND_DISPENSE)) begin
      we       = 1'b1;
      wr_stock = stock_q - CNT_W'(1);
      wr_cost  = cost_q;
    end else if (sup_gnt && item_ok) begin
      we       = 1'b1;
      wr_stock = sum_over ? MAX_CNT : sum[CNT_W-1:0];
      wr_cost  = (pcost_q == '0) ? rd_cost : pcost_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      op_q     <= VEND_QUERY;
      item_q   <= '0;
      count_q  <= '0;
      pcost_q  <= '0;
      stock_q  <= '0;
      cost_q   <= '0;
      sat_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (sup_win) begin
        item_q  <= sup_item;
        count_q <= sup_count;
        pcost_q <= sup_cost;
      end else if (vend_win) begin
        item_q <= vend_item;
        op_q   <= vend_op;
      end
      if (state_q == V_RD) begin
        stock_q <= rd_stock;
        cost_q  <= rd_cost;
      end
      if (sup_gnt) sat_q <= sat_now;
    end
  end

  assign vend_cost  = cost_q;
  assign vend_stock = stock_q;

endmodule
